// File: rtl/pattern_checker.sv
// Serial pattern checker: hunts for a repeating PAT_W-bit pattern in a strobed
// bit stream, then checks every strobed bit against the expected phase,
// counting checked bits and mismatches, and drops lock after LOSS_N
// consecutive mismatches.
module pattern_checker #(
    parameter int               PAT_W   = 8,
    parameter logic [PAT_W-1:0] PATTERN = 8'h53,
    parameter int               LOSS_N  = 3,
    parameter int               CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int IDX_W  = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int FILL_W = $clog2(PAT_W + 1);

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(PAT_W);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(PAT_W - 1);
    localparam logic [3:0]        MISS_LIMIT = 4'(LOSS_N);

    // Bit-reversed pattern so the phase index selects the MSB-first bit directly.
    function automatic logic [PAT_W-1:0] reverse_pattern(input logic [PAT_W-1:0] p);
        logic [PAT_W-1:0] r;
        r = '0;
        for (int i = 0; i < PAT_W; i++) begin
            r[i] = p[PAT_W-1-i];
        end
        return r;
    endfunction

    localparam logic [PAT_W-1:0] PAT_REV = reverse_pattern(PATTERN);

    // Saturating increment: the counter sticks at its all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        if (c == {CNT_W{1'b1}}) begin
            r = c;
        end else begin
            r = c + CNT_W'(1);
        end
        return r;
    endfunction

    logic [0:0]       state_r, state_s;
    logic [PAT_W-1:0] window_r, window_s;
    logic [FILL_W-1:0] fill_r, fill_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic [3:0]       miss_r, miss_s;
    logic [CNT_W-1:0] bit_cnt_r, bit_cnt_s;
    logic [CNT_W-1:0] err_cnt_r, err_cnt_s;
    logic             err_pulse_r, err_pulse_s;
    logic             exp_bit_s;
    logic [PAT_W-1:0] shifted_s;
    logic [FILL_W-1:0] fill_inc_s;
    logic [3:0]       miss_inc_s;

    assign exp_bit_s  = PAT_REV[idx_r];
    assign shifted_s  = {window_r[PAT_W-2:0], din};
    assign fill_inc_s = (fill_r == FILL_FULL) ? fill_r : (fill_r + FILL_W'(1));
    assign miss_inc_s = miss_r + 4'd1;

    // Next-state logic for the hunt/lock FSM, phase tracking and counters.
    always_comb begin
        state_s     = state_r;
        window_s    = window_r;
        fill_s      = fill_r;
        idx_s       = idx_r;
        miss_s      = miss_r;
        bit_cnt_s   = bit_cnt_r;
        err_cnt_s   = err_cnt_r;
        err_pulse_s = 1'b0;

        case (state_r)
            HUNT: begin
                if (en) begin
                    window_s = shifted_s;
                    fill_s   = fill_inc_s;
                    // Fill must be full so reset contents of the window can never match.
                    if ((fill_inc_s == FILL_FULL) && (shifted_s == PATTERN)) begin
                        state_s = LOCKED;
                        idx_s   = '0;
                        miss_s  = '0;
                    end else begin
                        state_s = HUNT;
                    end
                end else begin
                    state_s = HUNT;
                end
            end
            LOCKED: begin
                if (en) begin
                    idx_s     = (idx_r == IDX_LAST) ? '0 : (idx_r + IDX_W'(1));
                    bit_cnt_s = sat_inc(bit_cnt_r);
                    if (din != exp_bit_s) begin
                        err_pulse_s = 1'b1;
                        err_cnt_s   = sat_inc(err_cnt_r);
                        if (miss_inc_s >= MISS_LIMIT) begin
                            // Lock lost: restart the hunt from an empty window.
                            state_s  = HUNT;
                            window_s = '0;
                            fill_s   = '0;
                            idx_s    = '0;
                            miss_s   = '0;
                        end else begin
                            miss_s = miss_inc_s;
                        end
                    end else begin
                        miss_s = '0;
                    end
                end else begin
                    state_s = LOCKED;
                end
            end
            default: begin
                state_s  = HUNT;
                window_s = '0;
                fill_s   = '0;
                idx_s    = '0;
                miss_s   = '0;
            end
        endcase

        // Clear wins over any increment on the same edge.
        if (clear) begin
            bit_cnt_s = '0;
            err_cnt_s = '0;
        end else begin
            bit_cnt_s = bit_cnt_s;
            err_cnt_s = err_cnt_s;
        end
    end

    // State and output registers with asynchronous reset to the hunt state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= HUNT;
            window_r    <= '0;
            fill_r      <= '0;
            idx_r       <= '0;
            miss_r      <= '0;
            bit_cnt_r   <= '0;
            err_cnt_r   <= '0;
            err_pulse_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            window_r    <= window_s;
            fill_r      <= fill_s;
            idx_r       <= idx_s;
            miss_r      <= miss_s;
            bit_cnt_r   <= bit_cnt_s;
            err_cnt_r   <= err_cnt_s;
            err_pulse_r <= err_pulse_s;
        end
    end

    assign locked    = state_r;
    assign err_pulse = err_pulse_r;
    assign bit_cnt   = bit_cnt_r;
    assign err_cnt   = err_cnt_r;

endmodule
